// File: rtl/lsu_data_memory.sv
// -----------------------------------------------------------------------------
// lsu_data_memory
//
// Load/store data memory for the LSU. It takes one request at a time over a
// valid/ready handshake. The response appears LATENCY cycles after the request
// is accepted and is held until the consumer takes it. All RISC-V load and
// store sizes are supported. Loads are sign- or zero-extended. A misaligned,
// oversized or out-of-range access returns resp_err=1 with zero data, and a
// faulting store writes nothing.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     request present
//   req_ready     block is idle and can take a request
//   req_we        1 = store, 0 = load
//   req_size      log2 of the access size in bytes (0=B,1=H,2=W,3=D)
//   req_unsigned  zero-extend loads instead of sign-extending
//   req_addr      byte address
//   req_wdata     store data, taken from the low bytes
//   resp_valid    response available
//   resp_ready    consumer takes the response this cycle
//   resp_rdata    extended load data; zero for stores and faults
//   resp_err      access fault
// -----------------------------------------------------------------------------
module lsu_data_memory #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     DEPTH_WORDS = 128,
    parameter int unsigned     LATENCY     = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int unsigned BYTES  = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(BYTES);
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    // One past the last valid byte offset. The extra bit keeps the compare
    // exact even if the array fills the whole address space.
    localparam logic [XLEN:0]    LIMIT    = (XLEN+1)'(DEPTH_WORDS * BYTES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    // Request captured at accept, used when the access happens later (LATENCY > 1)
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;

    logic [XLEN-1:0]  r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_from_port;
    logic             w_we;
    logic [1:0]       w_size;
    logic             w_unsigned;
    logic [XLEN-1:0]  w_addr;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_off;
    logic [LANE_W-1:0] w_lane;
    logic [LANE_W-1:0] w_align_mask;
    logic [IDX_W-1:0] w_idx;
    logic             w_size_err;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_err;
    logic [XLEN-1:0]  w_word;
    logic [XLEN-1:0]  w_load;
    logic [XLEN-1:0]  w_merged;

    // -------------------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0, keep `size`
    // bytes, and fill the rest with the top kept bit (or zero when unsigned).
    // A full-width load has nothing to fill, so req_unsigned has no effect.
    // -------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0]   word,
        input logic [LANE_W-1:0] lane,
        input logic [1:0]        size,
        input logic              is_unsigned
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] keep;
        logic            sign_bit;
        logic            fill;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'd0: begin
                keep     = XLEN'(8'hFF);
                sign_bit = shifted[7];
            end
            2'd1: begin
                keep     = XLEN'(16'hFFFF);
                sign_bit = shifted[15];
            end
            2'd2: begin
                keep     = XLEN'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                keep     = '1;
                sign_bit = shifted[XLEN-1];
            end
        endcase
        fill = sign_bit & ~is_unsigned;
        return (shifted & keep) | (fill ? ~keep : '0);
    endfunction

    // -------------------------------------------------------------------------
    // Store merge: replace only the `size` bytes starting at `lane` with the
    // low bytes of the store data. All other bytes of the word are kept.
    // -------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0]   word,
        input logic [XLEN-1:0]   wdata,
        input logic [LANE_W-1:0] lane,
        input logic [1:0]        size
    );
        logic [BYTES-1:0] byte_en;
        logic [XLEN-1:0]  bit_en;
        logic [XLEN-1:0]  wshift;
        case (size)
            2'd0:    byte_en = BYTES'(8'h01);
            2'd1:    byte_en = BYTES'(8'h03);
            2'd2:    byte_en = BYTES'(8'h0F);
            default: byte_en = BYTES'(8'hFF);
        endcase
        byte_en = byte_en << lane;
        for (int b = 0; b < BYTES; b++) begin
            bit_en[b*8 +: 8] = {8{byte_en[b]}};
        end
        wshift = wdata << {lane, 3'b000};
        return (word & ~bit_en) | (wshift & bit_en);
    endfunction

    // -------------------------------------------------------------------------
    // Handshake events. Both are gated with reset: the state register ignores
    // edges while reset is low, so the memory and the capture registers must
    // ignore them too.
    // -------------------------------------------------------------------------
    assign w_accept     = reset && (r_state == S_IDLE) && req_valid;
    assign w_enter_resp = reset && (
                              ((r_state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                              ((r_state == S_WAIT) && (r_cnt == '0)));

    // With LATENCY == 1 the access happens on the accept edge itself, so the
    // request is taken straight from the ports. Otherwise the captured copy is used.
    assign w_from_port = (r_state == S_IDLE);
    assign w_we        = w_from_port ? req_we       : r_we;
    assign w_size      = w_from_port ? req_size     : r_size;
    assign w_unsigned  = w_from_port ? req_unsigned : r_unsigned;
    assign w_addr      = w_from_port ? req_addr     : r_addr;
    assign w_wdata     = w_from_port ? req_wdata    : r_wdata;

    // -------------------------------------------------------------------------
    // Address decode and fault detection
    // -------------------------------------------------------------------------
    assign w_off          = w_addr - BASE_ADDR;
    assign w_lane         = w_off[LANE_W-1:0];
    assign w_idx          = w_off[LANE_W +: IDX_W];
    assign w_align_mask   = LANE_W'((8'd1 << w_size) - 8'd1);
    assign w_size_err     = (XLEN == 32) && (w_size == 2'd3);
    assign w_misaligned   = (w_lane & w_align_mask) != '0;
    // An address below the base wraps to a large offset, but it is also
    // flagged explicitly in case BASE_ADDR sits near the top of the range.
    assign w_out_of_range = (w_addr < BASE_ADDR) || ({1'b0, w_off} >= LIMIT);
    assign w_err          = w_size_err | w_misaligned | w_out_of_range;

    assign w_word   = r_mem[w_idx];
    assign w_load   = load_extend(w_word, w_lane, w_size, w_unsigned);
    assign w_merged = store_merge(w_word, w_wdata, w_lane, w_size);

    // -------------------------------------------------------------------------
    // FSM: state register and latency counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
    end

    // -------------------------------------------------------------------------
    // Request capture. These are data registers and are not reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Memory array. It is never cleared. A store commits on the edge that
    // enters RESP, so a store abandoned by reset during WAIT never lands.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers, loaded on the same edge as the access
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            resp_rdata <= (w_we || w_err) ? '0 : w_load;
            resp_err   <= w_err;
        end
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
module tb_lsu_data_memory;

    localparam int NBYTES = 1024;   // 128 words of 8 bytes

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [63:0] req_addr     [2];
    logic [63:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [63:0] resp_rdata   [2];
    logic        resp_err     [2];

    lsu_data_memory #(.XLEN(64), .DEPTH_WORDS(128), .LATENCY(1), .BASE_ADDR(64'd0)) u_lat1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    lsu_data_memory #(.XLEN(64), .DEPTH_WORDS(128), .LATENCY(4), .BASE_ADDR(64'd0)) u_lat4 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        time         t_rise;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mm [2][NBYTES];   // byte-level reference memory per instance
    int  lat [2] = '{1, 4};
    bit  rand_bp;
    bit  force_low [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, faults on misalignment or range.
    task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] rd, output logic e);
        int nb;
        int a;
        nb = 1 << sz;
        e  = ((addr % 64'(nb)) != 0) || (addr >= 64'(NBYTES));
        rd = 64'd0;
        if (!e) begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < nb; i++) mm[d][a+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd = rd | (64'(mm[d][a+i]) << (8*i));
                if (!uns && nb < 8 && (((rd >> (8*nb-1)) & 64'd1) != 0))
                    rd = rd | ~((64'd1 << (8*nb)) - 64'd1);
            end
        end
    endtask

    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input bit use_k = 0, input logic [63:0] k_rd = 64'd0, input logic k_err = 1'b0);
        exp_t e;
        int   n;
        logic [63:0] m_rd;
        logic        m_err;
        n = 0;
        @(negedge clk);
        req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
        while (!req_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        model(d, we, sz, uns, addr, wd, m_rd, m_err);
        e.rdata  = use_k ? k_rd : m_rd;
        e.err    = use_k ? k_err : m_err;
        e.t_rise = $time + 64'((lat[d] - 1) * 10 + 5);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if ((q0.size() + q1.size()) != 0) chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    // Consumer side: random or forced backpressure, changed just after each edge
    initial begin
        resp_ready[0] = 1'b1;
        resp_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                resp_ready[d] = force_low[d] ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard whenever a response is taken
    bit          pv       [2];
    bit          exp_idle [2];
    logic [63:0] last_rd  [2];
    logic        last_err [2];
    time         rise_t   [2];

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pv[d]       = 1'b0;
                exp_idle[d] = 1'b0;
            end else begin
                if (exp_idle[d]) begin
                    chk("idle_after_resp", {62'd0, resp_valid[d], req_ready[d]}, 64'd1);
                    exp_idle[d] = 1'b0;
                end
                if (resp_valid[d]) begin
                    chk("req_ready_in_resp", {63'd0, req_ready[d]}, 64'd0);
                    if (!pv[d]) begin
                        rise_t[d] = $time;
                    end else begin
                        chk("hold_rdata", resp_rdata[d], last_rd[d]);
                        chk("hold_err", {63'd0, resp_err[d]}, {63'd0, last_err[d]});
                    end
                    last_rd[d]  = resp_rdata[d];
                    last_err[d] = resp_err[d];
                    if (resp_ready[d]) begin
                        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                            chk("unexpected_resp", 64'd1, 64'd0);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            chk(d == 0 ? "rdata_lat1" : "rdata_lat4", resp_rdata[d], e.rdata);
                            chk(d == 0 ? "err_lat1" : "err_lat4", {63'd0, resp_err[d]}, {63'd0, e.err});
                            chk(d == 0 ? "latency_lat1" : "latency_lat4", 64'(rise_t[d]), 64'(e.t_rise));
                        end
                        exp_idle[d] = 1'b1;
                    end
                end
                pv[d] = resp_valid[d];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        we, uns;
        logic [1:0]  sz;
        logic [63:0] addr;
        int          r, d;

        rst_n = 1'b0;
        rand_bp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0; req_unsigned[i] = 1'b0;
            req_addr[i] = 64'd0; req_wdata[i] = 64'd0; force_low[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_resp_valid", {63'd0, resp_valid[i]}, 64'd0);
            chk("reset_req_ready", {63'd0, req_ready[i]}, 64'd1);
            chk("reset_rdata", resp_rdata[i], 64'd0);
            chk("reset_err", {63'd0, resp_err[i]}, 64'd0);
        end
        rst_n = 1'b1;

        // Give every word a known value in both instances
        for (int w = 0; w < 128; w++)
            for (int i = 0; i < 2; i++)
                issue(i, 1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom, $urandom});

        // Directed accesses with literal expectations
        for (int i = 0; i < 2; i++) begin
            issue(i, 1, 2'd3, 0, 64'h100, 64'h1234567890ABCDEF, 1, 64'h0, 0);
            issue(i, 0, 2'd3, 0, 64'h100, 64'h0, 1, 64'h1234567890ABCDEF, 0);
            issue(i, 0, 2'd0, 0, 64'h100, 64'h0, 1, 64'hFFFFFFFFFFFFFFEF, 0);
            issue(i, 0, 2'd0, 1, 64'h100, 64'h0, 1, 64'h00000000000000EF, 0);
            issue(i, 0, 2'd1, 0, 64'h102, 64'h0, 1, 64'hFFFFFFFFFFFF90AB, 0);
            issue(i, 0, 2'd2, 0, 64'h104, 64'h0, 1, 64'h0000000012345678, 0);
            issue(i, 0, 2'd1, 1, 64'h106, 64'h0, 1, 64'h0000000000001234, 0);
            issue(i, 0, 2'd3, 1, 64'h100, 64'h0, 1, 64'h1234567890ABCDEF, 0);
            issue(i, 1, 2'd3, 0, 64'h200, 64'h0, 1, 64'h0, 0);
            issue(i, 1, 2'd2, 0, 64'h204, 64'hFFFF_FFFF_0000_000B, 1, 64'h0, 0);
            issue(i, 0, 2'd3, 0, 64'h200, 64'h0, 1, 64'h0000000B00000000, 0);
            issue(i, 1, 2'd0, 0, 64'h200, 64'h1234_56FF, 1, 64'h0, 0);
            issue(i, 0, 2'd3, 0, 64'h200, 64'h0, 1, 64'h0000000B000000FF, 0);
            issue(i, 0, 2'd2, 0, 64'h102, 64'h0, 1, 64'h0, 1);
            issue(i, 1, 2'd3, 0, 64'h404, 64'hDEAD, 1, 64'h0, 1);
            issue(i, 0, 2'd3, 0, 64'h400, 64'h0, 1, 64'h0, 1);
            issue(i, 1, 2'd1, 0, 64'h101, 64'hBEEF, 1, 64'h0, 1);
            issue(i, 0, 2'd3, 0, 64'h100, 64'h0, 1, 64'h1234567890ABCDEF, 0);
        end
        drain();

        // Backpressure on the LATENCY=4 instance
        force_low[1] = 1'b1;
        issue(1, 0, 2'd3, 0, 64'h100, 64'h0, 1, 64'h1234567890ABCDEF, 0);
        n = 0;
        while (!resp_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_valid", {63'd0, resp_valid[1]}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", {63'd0, resp_valid[1]}, 64'd1);
            chk("bp_req_ready", {63'd0, req_ready[1]}, 64'd0);
        end
        force_low[1] = 1'b0;
        drain();

        // Reset while a store is still in WAIT: the store must never land
        @(negedge clk);
        req_we[1] = 1'b1; req_size[1] = 2'd3; req_unsigned[1] = 1'b0;
        req_addr[1] = 64'h200; req_wdata[1] = 64'hDEAD; req_valid[1] = 1'b1;
        chk("rst_accept_ready", {63'd0, req_ready[1]}, 64'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_resp_valid", {63'd0, resp_valid[1]}, 64'd0);
        chk("rst_mid_req_ready", {63'd0, req_ready[1]}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_resp_valid", {63'd0, resp_valid[1]}, 64'd0);
            chk("post_rst_req_ready", {63'd0, req_ready[1]}, 64'd1);
        end
        issue(1, 0, 2'd3, 0, 64'h200, 64'h0, 1, 64'h0000000B000000FF, 0);
        drain();

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            d   = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 15));
            if (r == 0)      addr = 64'(NBYTES) + 64'($urandom_range(0, 2047));
            else if (r == 1) addr = 64'($urandom_range(0, NBYTES - 1));
            else if (r == 2) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            else             addr = (64'($urandom_range(0, NBYTES - 1)) >> sz) << sz;
            issue(d, we, sz, uns, addr, {$urandom, $urandom});
        end
        drain();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Parametrised load/store data memory that succeeds the fixed 64-bit single-cycle mem_stage.
- Adds configurable XLEN, depth and access latency, and supports all RISC-V load/store sizes with sign/zero extension.
- Uses a valid/ready request and response handshake, and flags misaligned and out-of-range accesses.
- Sits between the execute stage (which supplies address and data) and writeback; the processor stalls on req_ready/resp_valid.

Parameters:
XLEN, 64, data/address width; 32 or 64 only.
DEPTH_WORDS, 128, number of XLEN-bit words; power of two.
LATENCY, 1, cycles from request acceptance to resp_valid; must be >= 1.
BASE_ADDR, 0, byte address of word 0.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0=B, 1=H, 2=W, 3=D (funct3[1:0]).
req_unsigned  in  1  zero-extend loads (funct3[2]).
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data; low bytes are used.
resp_valid  out  1  response available.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  1  access fault.

Behaviour:
- FSM states are IDLE, WAIT and RESP.
  - req_ready = (state==IDLE).
  - resp_valid = (state==RESP).
- Reset (reset==0, async):
  - state goes to IDLE; latency counter = 0; resp_rdata = 0; resp_err = 0.
  - req_ready therefore reads 1, but no request is accepted while reset is low.
  - Memory array is NOT cleared.
- Accept:
  - An edge with state==IDLE and req_valid=1 accepts the request.
  - req_we, req_size, req_unsigned, req_addr and req_wdata are captured.
- Latency:
  - If LATENCY==1, the block goes directly to RESP.
  - Otherwise it goes to WAIT with cnt = LATENCY-2. WAIT decrements cnt and moves to RESP at the edge where cnt==0.
  - resp_valid rises exactly LATENCY cycles after the accept edge.
- Access occurs on the edge entering RESP:
  - The store write is committed at that edge.
  - resp_rdata and resp_err are registered at that same edge.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - word index = off >> log2(XLEN/8).
  - byte lane = off[log2(XLEN/8)-1:0].
  - Little-endian.
- Error conditions (any one sets resp_err=1, resp_rdata=0 and suppresses the store write):
  - size bytes (1<<req_size) > XLEN/8 (size D with XLEN=32);
  - lane not a multiple of size bytes (misaligned);
  - off >= DEPTH_WORDS*XLEN/8, or req_addr < BASE_ADDR.
- Loads:
  - Extract size bytes starting at lane.
  - Sign-extend from the top extracted bit unless req_unsigned=1.
  - A full-XLEN load ignores req_unsigned.
- Stores:
  - Only the size bytes at lane are written, taken from req_wdata low bytes.
  - Other bytes are unchanged.
  - resp_rdata = 0.
- RESP:
  - Held, with resp_rdata and resp_err stable, until resp_ready=1.
  - On that edge the block returns to IDLE.
  - No accept in the same cycle; minimum initiation interval is LATENCY+1 cycles.
- Reset mid-operation (WAIT or RESP):
  - Transaction abandoned; no response is produced.
  - A store not yet committed (still in WAIT) is never written.
  - A store already committed (in RESP) stays written.

Test Plan:
- Word 32 preset to 0x1234567890ABCDEF, XLEN=64, LATENCY=1: LD 0x100 -> resp_valid the cycle after accept, rdata=0x1234567890ABCDEF, err=0.
- Same word, sub-word loads:
  - LB 0x100 -> 0xFFFFFFFFFFFFFFEF.
  - LBU 0x100 -> 0x00000000000000EF.
  - LH 0x102 -> 0xFFFFFFFFFFFF90AB.
  - LW 0x104 -> 0x0000000012345678.
  - LHU 0x106 -> 0x1234.
- Word 64 cleared:
  - SW wdata=0xB at 0x204, then LD 0x200 -> 0x0000000B00000000.
  - SB 0xFF at 0x200, then LD 0x200 -> 0x0000000B000000FF.
- Faults, each -> err=1, rdata=0, memory unchanged:
  - LW 0x102;
  - SD 0x404;
  - LD 0x400 with DEPTH_WORDS=128.
- LATENCY=4 and backpressure:
  - Accept at cycle 0 -> resp_valid at cycle 4.
  - Hold resp_ready=0 for 3 cycles -> rdata/err stable and req_ready=0.
  - Release -> IDLE next cycle.
- Reset mid-op, LATENCY=4:
  - SD 0xDEAD at 0x200 accepted, reset low 2 cycles later -> resp_valid=0, req_ready=1 after release, LD 0x200 returns prior contents.
